// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master/slave views.
// Clock and reset stay outside the interface as plain module ports.
interface axi4_lite_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register file: write commits and BVALID rise 1 edge after AW+W capture, RVALID 1 edge after AR.
// A captured AW or W channel holds its READY low until B completes; B and R outputs hold until READY.
module axi4_lite_slave #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  localparam int NUM_REGS = 2 ** (ADDR_W - 2)
) (
  input  logic                         i_aclk,
  input  logic                         i_areset,
  axi4_lite_slave_if.slave             s_axi,
  output logic [NUM_REGS*DATA_W-1:0]   o_regs
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {B_IDLE, B_VALID} b_state_t;
  typedef enum logic {R_IDLE, R_VALID} r_state_t;

  b_state_t          r_b_state, w_b_next;
  r_state_t          r_r_state, w_r_next;
  logic              r_aw_flag, r_w_flag;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_bresp;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic w_aw_rdy, w_w_rdy, w_ar_rdy;
  logic w_aw_hs, w_w_hs, w_ar_hs;
  logic w_commit, w_b_hs, w_r_hs;
  logic w_aw_aligned, w_ar_aligned;

  assign w_aw_aligned = (r_awaddr[1:0] == 2'b00);
  assign w_ar_aligned = (s_axi.araddr[1:0] == 2'b00);

  // READYs are gated by reset so they read low during the reset cycle itself.
  always_comb begin
    w_b_next = r_b_state;
    w_aw_rdy = 1'b0;
    w_w_rdy  = 1'b0;
    w_commit = 1'b0;
    w_b_hs   = 1'b0;
    case (r_b_state)
      B_IDLE: begin
        w_aw_rdy = !i_areset && !r_aw_flag;
        w_w_rdy  = !i_areset && !r_w_flag;
        w_commit = r_aw_flag && r_w_flag;
        if (w_commit) w_b_next = B_VALID;
      end
      B_VALID: begin
        w_b_hs = s_axi.bready;
        if (w_b_hs) w_b_next = B_IDLE;
      end
      default: w_b_next = B_IDLE;
    endcase
  end

  always_comb begin
    w_r_next = r_r_state;
    w_ar_rdy = 1'b0;
    w_r_hs   = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        w_ar_rdy = !i_areset;
        if (s_axi.arvalid && w_ar_rdy) w_r_next = R_VALID;
      end
      R_VALID: begin
        w_r_hs = s_axi.rready;
        if (w_r_hs) w_r_next = R_IDLE;
      end
      default: w_r_next = R_IDLE;
    endcase
  end

  assign w_aw_hs = s_axi.awvalid && w_aw_rdy;
  assign w_w_hs  = s_axi.wvalid && w_w_rdy;
  assign w_ar_hs = s_axi.arvalid && w_ar_rdy;

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_b_state <= B_IDLE;
      r_r_state <= R_IDLE;
    end else begin
      r_b_state <= w_b_next;
      r_r_state <= w_r_next;
    end
  end

  // Non-blocking update means a same-edge AR sees the pre-write register value.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_aw_flag <= 1'b0;
      r_w_flag  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_bresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awaddr  <= s_axi.awaddr;
        r_aw_flag <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= s_axi.wdata;
        r_w_flag <= 1'b1;
      end
      if (w_commit) begin
        if (w_aw_aligned) r_regs[r_awaddr[ADDR_W-1:2]] <= r_wdata;
        r_bresp <= w_aw_aligned ? RESP_OKAY : RESP_SLVERR;
      end
      if (w_b_hs) begin
        r_aw_flag <= 1'b0;
        r_w_flag  <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rdata <= w_ar_aligned ? r_regs[s_axi.araddr[ADDR_W-1:2]] : '0;
        r_rresp <= w_ar_aligned ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi.awready = w_aw_rdy;
  assign s_axi.wready  = w_w_rdy;
  assign s_axi.bvalid  = (r_b_state == B_VALID);
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = w_ar_rdy;
  assign s_axi.rvalid  = (r_r_state == R_VALID);
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_regs[g*DATA_W +: DATA_W] = r_regs[g];
  end
endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave: stimulus pushes expected B/R responses into queues,
// a negedge monitor pops and compares them on every B and R handshake.
module tb_axi4_lite_slave;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] regs;

  always #5 clk = ~clk;

  axi4_lite_slave_if #(.ADDR_W(4), .DATA_W(32)) bus();

  axi4_lite_slave #(.ADDR_W(4), .DATA_W(32)) dut (
    .i_aclk   (clk),
    .i_areset (rst),
    .s_axi    (bus),
    .o_regs   (regs)
  );

  int errors = 0;
  int checks = 0;
  int b_seen = 0;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [1:0]  eb;
    logic [33:0] er;
    if (!rst && bus.bvalid && bus.bready) begin
      b_seen++;
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got bresp %b with no response expected", bus.bresp);
      end else begin
        eb = exp_b.pop_front();
        chk("bresp", 32'(bus.bresp), 32'(eb));
      end
    end
    if (!rst && bus.rvalid && bus.rready) begin
      if (exp_r.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected: got rdata %h with no response expected", bus.rdata);
      end else begin
        er = exp_r.pop_front();
        chk("rdata", bus.rdata, er[31:0]);
        chk("rresp", 32'(bus.rresp), 32'(er[33:32]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d responses outstanding expected 0", name,
               exp_b.size() + exp_r.size());
      exp_b.delete();
      exp_r.delete();
    end
    tick();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [1:0] r);
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    exp_b.push_back(r);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] d, input logic [1:0] r);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    exp_r.push_back({r, d});
    tick();
    bus.arvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    int b_before;
    int n;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // Reset state, sampled during the reset cycle
    tick();
    @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 32'h0);
    chk("rst_wready",  32'(bus.wready),  32'h0);
    chk("rst_arready", 32'(bus.arready), 32'h0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'h0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'h0);
    chk("rst_bresp",   32'(bus.bresp),   32'h0);
    chk("rst_rresp",   32'(bus.rresp),   32'h0);
    chk("rst_rdata",   bus.rdata,        32'h0);
    for (int i = 0; i < 4; i++) chk("rst_regs", regs[i*32 +: 32], 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_awready", 32'(bus.awready), 32'h1);
    chk("rel_wready",  32'(bus.wready),  32'h1);
    chk("rel_arready", 32'(bus.arready), 32'h1);
    tick();

    // AW+W same cycle to reg1: BVALID exactly one edge after the handshake
    do_write(4'd4, 32'hDEADBEEF, 2'b00);
    @(negedge clk);
    chk("wr_lat_bvalid0", 32'(bus.bvalid), 32'h0);
    chk("wr_awready_held", 32'(bus.awready), 32'h0);
    chk("wr_reg1_before", regs[63:32], 32'h0);
    @(negedge clk);
    chk("wr_lat_bvalid1", 32'(bus.bvalid), 32'h1);
    chk("wr_reg1", regs[63:32], 32'hDEADBEEF);
    drain("wr_same_cycle");

    // W first, AW three cycles later to reg2
    b_before = b_seen;
    bus.wdata  = 32'h12345678;
    bus.wvalid = 1'b1;
    exp_b.push_back(2'b00);
    tick();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_first_wready", 32'(bus.wready), 32'h0);
      chk("w_first_bvalid", 32'(bus.bvalid), 32'h0);
      tick();
    end
    bus.awaddr  = 4'd8;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    drain("w_first");
    chk("w_first_single_b", 32'(b_seen - b_before), 32'd1);
    @(negedge clk);
    chk("w_first_reg2", regs[95:64], 32'h12345678);
    tick();

    // Read reg1 with RREADY low for 4 cycles: outputs stable, ARREADY low
    bus.rready  = 1'b0;
    bus.araddr  = 4'd4;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rd_hold_rvalid",  32'(bus.rvalid),  32'h1);
      chk("rd_hold_rdata",   bus.rdata,        32'hDEADBEEF);
      chk("rd_hold_arready", 32'(bus.arready), 32'h0);
      tick();
    end
    exp_r.push_back({2'b00, 32'hDEADBEEF});
    bus.rready = 1'b1;
    drain("rd_hold");

    // Unaligned write and read
    do_write(4'd6, 32'hFFFFFFFF, 2'b10);
    drain("wr_unaligned");
    @(negedge clk);
    chk("unal_reg0", regs[31:0],   32'h0);
    chk("unal_reg1", regs[63:32],  32'hDEADBEEF);
    chk("unal_reg2", regs[95:64],  32'h12345678);
    chk("unal_reg3", regs[127:96], 32'h0);
    tick();
    do_read(4'd6, 32'h0, 2'b10);
    drain("rd_unaligned");

    // Write commit and AR to reg0 on the same edge returns the old value
    do_write(4'd0, 32'h1, 2'b00);
    drain("wr_reg0");
    bus.awaddr  = 4'd0;
    bus.wdata   = 32'h2;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    exp_b.push_back(2'b00);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.araddr  = 4'd0;
    bus.arvalid = 1'b1;
    exp_r.push_back({2'b00, 32'h1});
    tick();
    bus.arvalid = 1'b0;
    drain("same_edge");
    do_read(4'd0, 32'h2, 2'b00);
    drain("rd_after_same_edge");

    // Reset while both BVALID and RVALID are pending
    bus.bready  = 1'b0;
    bus.rready  = 1'b0;
    bus.awaddr  = 4'd12;
    bus.wdata   = 32'hA5A5A5A5;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.araddr  = 4'd4;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.bvalid && bus.rvalid) && n < 10);
    chk("pre_rst_bvalid", 32'(bus.bvalid), 32'h1);
    chk("pre_rst_rvalid", 32'(bus.rvalid), 32'h1);
    chk("pre_rst_reg3",   regs[127:96],    32'hA5A5A5A5);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_bvalid",  32'(bus.bvalid),  32'h0);
    chk("mid_rst_rvalid",  32'(bus.rvalid),  32'h0);
    chk("mid_rst_awready", 32'(bus.awready), 32'h0);
    chk("mid_rst_arready", 32'(bus.arready), 32'h0);
    for (int i = 0; i < 4; i++) chk("mid_rst_regs", regs[i*32 +: 32], 32'h0);
    tick();
    rst = 1'b0;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 32'(bus.awready), 32'h1);
    chk("post_rst_wready",  32'(bus.wready),  32'h1);
    chk("post_rst_arready", 32'(bus.arready), 32'h1);
    chk("post_rst_bvalid",  32'(bus.bvalid),  32'h0);
    tick();
    tick();
    chk("queues_empty", 32'(exp_b.size() + exp_r.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
